// File: rtl/data_mem_be.sv
// Single-port data memory with byte write enables, registered read and a
// constant-fill engine that takes over the array one word per cycle.
module data_mem_be #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512,
   localparam int BE_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              wen,
   input  logic [BE_W-1:0]   be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic              ready,
   output logic [DATA_W-1:0] dout,
   output logic              rvalid,
   output logic              err,
   input  logic              fill_start,
   input  logic [ADDR_W-1:0] fill_base,
   input  logic [ADDR_W:0]   fill_len,
   input  logic [DATA_W-1:0] fill_data,
   output logic              fill_busy,
   output logic              fill_done
);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] fdata_q, fdata_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              rvalid_q, rvalid_d;
   logic              err_q, err_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [BE_W-1:0]   mem_be;
   logic [DATA_W-1:0] mem_wdata;
   logic              addr_ok;
   logic [IDX_W-1:0]  rd_idx, wr_idx;

   // Indices are only used once the address is known to be in range,
   // so dropping the upper bits is safe.
   assign addr_ok = {1'b0, addr} < DEPTH_L;
   assign rd_idx  = addr[IDX_W-1:0];
   assign wr_idx  = mem_addr[IDX_W-1:0];

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      fdata_d   = fdata_q;
      dout_d    = dout_q;
      rvalid_d  = 1'b0;
      err_d     = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = addr;
      mem_be    = be;
      mem_wdata = din;
      case (state_q)
         IDLE: begin
            // A fill request outranks the CPU; ready is low in that cycle.
            if (fill_start) begin
               if ({1'b0, fill_base} >= DEPTH_L) begin
                  err_d = 1'b1;
               end else if (fill_len == '0) begin
                  state_d = DONE;
               end else begin
                  ptr_d   = fill_base;
                  fdata_d = fill_data;
                  cnt_d   = (fill_len > DEPTH_L) ? DEPTH_L : fill_len;
                  state_d = FILL;
               end
            end else if (req) begin
               if (!addr_ok) begin
                  err_d = 1'b1;
                  if (!wen) begin
                     rvalid_d = 1'b1;
                     dout_d   = '0;
                  end
               end else if (wen) begin
                  mem_we = 1'b1;
               end else begin
                  rvalid_d = 1'b1;
                  dout_d   = mem[rd_idx];
               end
            end
         end
         FILL: begin
            mem_we    = 1'b1;
            mem_addr  = ptr_q;
            mem_be    = '1;
            mem_wdata = fdata_q;
            ptr_d     = ({1'b0, ptr_q} == LAST_L) ? '0 : ptr_q + 1'b1;
            cnt_d     = cnt_q - ONE_L;
            if (cnt_q == ONE_L) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < BE_W; b++) begin
            if (mem_be[b]) mem[wr_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         cnt_q    <= '0;
         fdata_q  <= '0;
         dout_q   <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         fdata_q  <= fdata_d;
         dout_q   <= dout_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   assign ready     = (state_q == IDLE) && !fill_start;
   assign dout      = dout_q;
   assign rvalid    = rvalid_q;
   assign err       = err_q;
   assign fill_busy = (state_q != IDLE);
   assign fill_done = (state_q == DONE);

endmodule
